// File: rtl/viterbi_pkg.sv
// Shared trellis helpers for the Viterbi add-compare-select datapath.
// Predecessor/branch indexing, saturating add and the normalisation constant.
package viterbi_pkg;

  localparam int M_DEF = 2;
  localparam int S     = 2 ** M_DEF;

  // Trellis shifts the new bit into the LSB, so predecessors differ only in their MSB.
  function automatic int pred0(input int ns, input int m);
    return (ns >> 1) & ((1 << (m - 1)) - 1);
  endfunction

  function automatic int pred1(input int ns, input int m);
    return (1 << (m - 1)) | ((ns >> 1) & ((1 << (m - 1)) - 1));
  endfunction

  function automatic int bm_idx(input int prev, input int u);
    return (prev << 1) | (u & 1);
  endfunction

  function automatic int sat_add(input int a, input int b, input int w);
    int sum;
    int max_v;
    sum   = a + b;
    max_v = (1 << w) - 1;
    return (sum > max_v) ? max_v : sum;
  endfunction

  function automatic int norm_const(input int w);
    return 1 << (w - 1);
  endfunction

endpackage

// File: rtl/acs_cell.sv
// One trellis state: two saturating adds, strict compare, select.
// Ties keep the lower predecessor, so dec_o is 1 only when the upper path is strictly better.
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int BM_W = 4,
  parameter int PM_W = 8
) (
  input  logic [PM_W-1:0] pm0_i,
  input  logic [PM_W-1:0] pm1_i,
  input  logic [BM_W-1:0] bm0_i,
  input  logic [BM_W-1:0] bm1_i,
  output logic [PM_W-1:0] pm_o,
  output logic            msb_o,
  output logic            dec_o
);

  logic [PM_W-1:0] c0_s;
  logic [PM_W-1:0] c1_s;

  // Add both candidates with saturation, then pick the strictly smaller one.
  always_comb begin
    c0_s = PM_W'(sat_add(int'(pm0_i), int'(bm0_i), PM_W));
    c1_s = PM_W'(sat_add(int'(pm1_i), int'(bm1_i), PM_W));
    if (c1_s < c0_s) begin
      pm_o  = c1_s;
      dec_o = 1'b1;
    end else begin
      pm_o  = c0_s;
      dec_o = 1'b0;
    end
  end

  assign msb_o = pm_o[PM_W-1];

endmodule

// File: rtl/acs_array.sv
// Parametrised ACS array: path metrics, normalisation, register-exchange survivors,
// best-state search and traceback-window fill tracking, all with one cycle of latency.
module acs_array
  import viterbi_pkg::*;
#(
  parameter int M        = 2,
  parameter int BM_W     = 4,
  parameter int PM_W     = 8,
  parameter int TB_DEPTH = 8,
  parameter int INIT_PM  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         valid_in,
  input  logic                         start,
  input  logic [2*(2**M)*BM_W-1:0]     bm_in,
  output logic                         valid_out,
  output logic [(2**M)*PM_W-1:0]       pm_out,
  output logic [(2**M)-1:0]            dec_out,
  output logic [(2**M)*TB_DEPTH-1:0]   surv_out,
  output logic [M-1:0]                 best_state,
  output logic                         dec_bit,
  output logic                         dec_valid
);

  localparam int NS = 2 ** M;
  localparam int FW = $clog2(TB_DEPTH + 1);

  logic [PM_W-1:0]     pm_q     [NS];
  logic [PM_W-1:0]     pm_d     [NS];
  logic [TB_DEPTH-1:0] surv_q   [NS];
  logic [TB_DEPTH-1:0] surv_d   [NS];
  logic [NS-1:0]       dec_q;
  logic [NS-1:0]       dec_d;
  logic [M-1:0]        best_q;
  logic [M-1:0]        best_d;
  logic [FW-1:0]       fill_q;
  logic [FW-1:0]       fill_d;
  logic                valid_q;
  logic                dec_valid_q;

  logic [PM_W-1:0]     src_pm_s   [NS];
  logic [TB_DEPTH-1:0] src_surv_s [NS];
  logic [PM_W-1:0]     sel_pm_s   [NS];
  logic [NS-1:0]       sel_msb_s;
  logic                all_msb_s;
  logic [PM_W-1:0]     best_pm_s;
  logic [TB_DEPTH-1:0] pick_s;

  // Frame start replaces the stored metrics/survivors with the known-start-state seed.
  always_comb begin
    for (int s = 0; s < NS; s++) begin
      if (start) begin
        src_pm_s[s]   = (s == 0) ? '0 : PM_W'(INIT_PM);
        src_surv_s[s] = '0;
      end else begin
        src_pm_s[s]   = pm_q[s];
        src_surv_s[s] = surv_q[s];
      end
    end
  end

  for (genvar ns = 0; ns < NS; ns++) begin : g_acs
    localparam int P0 = pred0(ns, M);
    localparam int P1 = pred1(ns, M);
    localparam int U  = ns % 2;

    acs_cell #(
      .BM_W (BM_W),
      .PM_W (PM_W)
    ) u_cell (
      .pm0_i (src_pm_s[P0]),
      .pm1_i (src_pm_s[P1]),
      .bm0_i (bm_in[bm_idx(P0, U)*BM_W +: BM_W]),
      .bm1_i (bm_in[bm_idx(P1, U)*BM_W +: BM_W]),
      .pm_o  (sel_pm_s[ns]),
      .msb_o (sel_msb_s[ns]),
      .dec_o (dec_d[ns])
    );
  end

  assign all_msb_s = &sel_msb_s;

  // Normalise and exchange survivors; the newest decision enters at the LSB.
  always_comb begin
    pick_s = '0;
    for (int s = 0; s < NS; s++) begin
      if (all_msb_s) begin
        pm_d[s] = sel_pm_s[s] - PM_W'(norm_const(PM_W));
      end else begin
        pm_d[s] = sel_pm_s[s];
      end
      if (dec_d[s]) begin
        pick_s = src_surv_s[M'(pred1(s, M))];
      end else begin
        pick_s = src_surv_s[M'(pred0(s, M))];
      end
      surv_d[s] = {pick_s[TB_DEPTH-2:0], s[0]};
    end
  end

  // Minimum search over the new metrics; strict compare keeps the lowest index on ties.
  always_comb begin
    best_d    = '0;
    best_pm_s = pm_d[0];
    for (int s = 1; s < NS; s++) begin
      if (pm_d[s] < best_pm_s) begin
        best_pm_s = pm_d[s];
        best_d    = M'(s);
      end else begin
        best_pm_s = best_pm_s;
      end
    end
  end

  // Fill counter: restart on frame start, otherwise count up and saturate.
  always_comb begin
    if (start) begin
      fill_d = FW'(1);
    end else if (fill_q == FW'(TB_DEPTH)) begin
      fill_d = fill_q;
    end else begin
      fill_d = fill_q + FW'(1);
    end
  end

  // State update on accepted symbols; reset clears everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < NS; s++) begin
        pm_q[s]   <= '0;
        surv_q[s] <= '0;
      end
      dec_q       <= '0;
      best_q      <= '0;
      fill_q      <= '0;
      valid_q     <= 1'b0;
      dec_valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        for (int s = 0; s < NS; s++) begin
          pm_q[s]   <= pm_d[s];
          surv_q[s] <= surv_d[s];
        end
        dec_q       <= dec_d;
        best_q      <= best_d;
        fill_q      <= fill_d;
        dec_valid_q <= (fill_d == FW'(TB_DEPTH));
      end else begin
        dec_valid_q <= 1'b0;
      end
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_out
    assign pm_out[s*PM_W +: PM_W]             = pm_q[s];
    assign surv_out[s*TB_DEPTH +: TB_DEPTH]   = surv_q[s];
  end

  assign valid_out  = valid_q;
  assign dec_out    = dec_q;
  assign best_state = best_q;
  assign dec_valid  = dec_valid_q;
  assign dec_bit    = surv_q[best_q][TB_DEPTH-1];

endmodule

// File: tb/tb_acs_array.sv
// Scoreboard bench for acs_array: a trellis-level reference model pushes expectations,
// a negedge monitor pops and compares whenever valid_out is seen.
module tb_acs_array;

  localparam int M       = 2;
  localparam int S       = 4;
  localparam int BM_W    = 4;
  localparam int PM_W    = 8;
  localparam int TB      = 8;
  localparam int INIT_PM = 64;
  localparam int PM_MAX  = 255;
  localparam int HALF    = 128;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   valid_in = 1'b0;
  logic                   start = 1'b0;
  logic [2*S*BM_W-1:0]    bm_in = '0;
  logic                   valid_out;
  logic [S*PM_W-1:0]      pm_out;
  logic [S-1:0]           dec_out;
  logic [S*TB-1:0]        surv_out;
  logic [M-1:0]           best_state;
  logic                   dec_bit;
  logic                   dec_valid;

  acs_array #(
    .M (M), .BM_W (BM_W), .PM_W (PM_W), .TB_DEPTH (TB), .INIT_PM (INIT_PM)
  ) dut (
    .clk (clk), .rst (rst), .valid_in (valid_in), .start (start), .bm_in (bm_in),
    .valid_out (valid_out), .pm_out (pm_out), .dec_out (dec_out), .surv_out (surv_out),
    .best_state (best_state), .dec_bit (dec_bit), .dec_valid (dec_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [S*PM_W-1:0] pm;
    logic [S-1:0]      dec;
    logic [S*TB-1:0]   surv;
    logic [M-1:0]      best;
    logic              dbit;
    logic              dval;
    int                ref_bit;
    bit                has_cpm;
    logic [S*PM_W-1:0] cpm;
    bit                has_cdec;
    logic [S-1:0]      cdec;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   rst_active = 1'b1;

  int m_pm[S];
  int m_surv[S];
  int m_fill;
  int bmv[2*S];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: for each next state search every predecessor that shifts into it.
  task automatic model_step(input bit st, output exp_t e);
    int src_pm[S];
    int src_sv[S];
    int npm[S];
    int nsv[S];
    int bp, bc, c, u, best;
    bit all_hi;
    e.dec = '0;
    for (int s = 0; s < S; s++) begin
      src_pm[s] = st ? ((s == 0) ? 0 : INIT_PM) : m_pm[s];
      src_sv[s] = st ? 0 : m_surv[s];
    end
    for (int ns = 0; ns < S; ns++) begin
      u  = ns % 2;
      bp = -1;
      bc = 0;
      for (int p = 0; p < S; p++) begin
        if (((p * 2 + u) % S) == ns) begin
          c = src_pm[p] + bmv[p * 2 + u];
          if (c > PM_MAX) c = PM_MAX;
          if (bp < 0 || c < bc) begin
            bp = p;
            bc = c;
          end
        end
      end
      npm[ns] = bc;
      nsv[ns] = (src_sv[bp] * 2 + u) % (1 << TB);
      e.dec[ns] = (bp >= S / 2);
    end
    all_hi = 1'b1;
    for (int s = 0; s < S; s++) if (npm[s] < HALF) all_hi = 1'b0;
    if (all_hi) for (int s = 0; s < S; s++) npm[s] = npm[s] - HALF;
    m_fill = st ? 1 : ((m_fill < TB) ? m_fill + 1 : TB);
    best = 0;
    for (int s = 1; s < S; s++) if (npm[s] < npm[best]) best = s;
    for (int s = 0; s < S; s++) begin
      e.pm[s*PM_W +: PM_W] = PM_W'(npm[s]);
      e.surv[s*TB +: TB]   = TB'(nsv[s]);
      m_pm[s]   = npm[s];
      m_surv[s] = nsv[s];
    end
    e.best = M'(best);
    e.dbit = ((nsv[best] >> (TB - 1)) & 1) != 0;
    e.dval = (m_fill == TB);
  endtask

  task automatic send(input bit st, input int refb, input bit hc, input logic [S*PM_W-1:0] cpm,
                      input bit hd, input logic [S-1:0] cdec);
    exp_t e;
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    start    = st;
    for (int t = 0; t < 2 * S; t++) bm_in[t*BM_W +: BM_W] = BM_W'(bmv[t]);
    model_step(st, e);
    e.ref_bit  = refb;
    e.has_cpm  = hc;
    e.cpm      = cpm;
    e.has_cdec = hd;
    e.cdec     = cdec;
    q.push_back(e);
  endtask

  task automatic send_rand(input bit st);
    for (int t = 0; t < 2 * S; t++) bmv[t] = $urandom_range(0, 15);
    send(st, -1, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic gap();
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    start    = 1'($urandom_range(0, 1));
    bm_in    = 32'($urandom);
  endtask

  task automatic do_reset();
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_active = 1'b1;
    rst        = 1'b0;
    valid_in   = 1'b1;
    start      = 1'($urandom_range(0, 1));
    bm_in      = 32'($urandom);
    q.delete();
    for (int s = 0; s < S; s++) begin
      m_pm[s]   = 0;
      m_surv[s] = 0;
    end
    m_fill    = 0;
    last.pm   = '0;
    last.surv = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid_out", valid_out, 0);
    check("rst_pm", pm_out, 0);
    check("rst_surv", surv_out, 0);
    check("rst_dec", dec_out, 0);
    check("rst_best", best_state, 0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_dec_bit", dec_bit, 0);
    #1;
    rst        = 1'b1;
    valid_in   = 1'b0;
    rst_active = 1'b0;
  endtask

  // Monitor: compare every presented output against the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_active) begin
      if (valid_out) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_valid: got valid_out=1 expected no pending symbol");
        end else begin
          e = q.pop_front();
          check("pm_out", pm_out, e.pm);
          check("dec_out", dec_out, e.dec);
          check("surv_out", surv_out, e.surv);
          check("best_state", best_state, e.best);
          check("dec_bit", dec_bit, e.dbit);
          check("dec_valid", dec_valid, e.dval);
          if (e.ref_bit >= 0) check("decoded_bit", dec_bit, 64'(e.ref_bit));
          if (e.has_cpm) check("pm_const", pm_out, e.cpm);
          if (e.has_cdec) check("dec_const", dec_out, e.cdec);
          last = e;
        end
      end else begin
        check("hold_pm", pm_out, last.pm);
        check("hold_surv", surv_out, last.surv);
        check("gap_dec_valid", dec_valid, 0);
      end
    end
  end

  initial begin
    bit b[20];
    int r;

    do_reset();

    // Known start vector: metrics {1,3,66,67}, only state 3 takes its upper predecessor.
    bmv = '{1, 3, 2, 4, 2, 1, 2, 3};
    send(1'b1, -1, 1'b1, {8'd67, 8'd66, 8'd3, 8'd1}, 1'b1, 4'b1000);
    gap();
    gap();

    // Equal branch metrics: every decision is a tie or favours the lower predecessor.
    for (int t = 0; t < 2 * S; t++) bmv[t] = 2;
    send(1'b1, -1, 1'b0, '0, 1'b1, 4'b0000);
    send(1'b0, -1, 1'b0, '0, 1'b1, 4'b0000);
    send(1'b0, -1, 1'b0, '0, 1'b1, 4'b0000);

    // Maximum branch metrics drive repeated normalisation.
    for (int t = 0; t < 2 * S; t++) bmv[t] = 15;
    for (int n = 0; n < 40; n++) send(n == 0, -1, 1'b0, '0, 1'b0, '0);

    // Noiseless decode: the decided bit lags the input by the window length minus one.
    for (int n = 0; n < 20; n++) b[n] = 1'($urandom_range(0, 1));
    for (int n = 0; n < 20; n++) begin
      for (int t = 0; t < 2 * S; t++) bmv[t] = ((t % 2) == int'(b[n])) ? 0 : 7;
      send(n == 0, (n >= TB - 1) ? int'(b[n - TB + 1]) : -1, 1'b0, '0, 1'b0, '0);
      if (n == 10) gap();
    end
    gap();

    // Mid-frame restart, then reset mid-frame and continue without start.
    for (int n = 0; n < 5; n++) send_rand(n == 0);
    send_rand(1'b1);
    for (int n = 0; n < 9; n++) send_rand(1'b0);
    do_reset();
    for (int n = 0; n < 4; n++) send_rand(1'b0);

    // Random mix of symbols, gaps, restarts and resets.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12) gap();
      else if (r < 18) send_rand(1'b1);
      else if (r < 20) do_reset();
      else send_rand(1'b0);
    end

    repeat (3) gap();
    @(negedge clk);
    check("queue_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
